// File: rtl/seq_multiplier_pkg.sv
// Shared types and sizing helpers for the iterative shift-add multiplier.
// Imported by the multiplier top and its bench.
package seq_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } seq_mul_state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Operand/product handshake bundle for seq_multiplier.
// master drives operands and out_ready; slave is the multiplier.
interface seq_multiplier_if #(
  parameter int W = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           in_signed;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_prod;

  modport master (
    output in_valid, in_a, in_b,
    output in_signed, out_ready,
    input  in_ready, out_valid, out_prod
  );

  modport slave (
    input  in_valid, in_a, in_b,
    input  in_signed, out_ready,
    output in_ready, out_valid, out_prod
  );
endinterface

// File: rtl/seq_multiplier_cond_negate.sv
// Conditional two's-complement negation: o_out = i_neg ? -i_in : i_in.
// Used for operand magnitudes and the final product sign fix.
module cond_negate #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_in,
  input  logic         i_neg,
  output logic [W-1:0] o_out
);
  assign o_out = i_neg ? -i_in : i_in;
endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, signed or unsigned per operation.
// Build option: SEQ_MULTIPLIER_EARLY_EXIT_EN ends BUSY once b is exhausted.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int W = 8
) (
  input  logic            clk,
  input  logic            reset,
  seq_multiplier_if.slave bus
);
  localparam int CW = cnt_w(W);

  seq_mul_state_t r_state;
  logic [2*W-1:0] r_mcand;
  logic [2*W-1:0] r_acc;
  logic [2*W-1:0] r_prod;
  logic [W-1:0]   r_mplier;
  logic [CW-1:0]  r_cnt;
  logic           r_neg;

  logic [W-1:0]   w_abs_a;
  logic [W-1:0]   w_abs_b;
  logic [W-1:0]   w_mplier_nxt;
  logic [2*W-1:0] w_acc_nxt;
  logic [2*W-1:0] w_prod;
  logic           w_neg_a;
  logic           w_neg_b;
  logic           w_last;

  assign w_neg_a = bus.in_signed & bus.in_a[W-1];
  assign w_neg_b = bus.in_signed & bus.in_b[W-1];

  cond_negate #(.W(W)) u_abs_a (
    .i_in  (bus.in_a),
    .i_neg (w_neg_a),
    .o_out (w_abs_a)
  );

  cond_negate #(.W(W)) u_abs_b (
    .i_in  (bus.in_b),
    .i_neg (w_neg_b),
    .o_out (w_abs_b)
  );

  assign w_mplier_nxt = r_mplier >> 1;
  assign w_acc_nxt    = r_acc + (r_mplier[0] ? r_mcand : '0);

  // Sign fix applies to the accumulator including this cycle's add.
  cond_negate #(.W(2*W)) u_sign (
    .i_in  (w_acc_nxt),
    .i_neg (r_neg),
    .o_out (w_prod)
  );

`ifdef SEQ_MULTIPLIER_EARLY_EXIT_EN
  assign w_last = (r_cnt == CW'(W-1)) ||
                  (w_mplier_nxt == '0);
`else
  assign w_last = (r_cnt == CW'(W-1));
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_prod   <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_mcand  <= {{W{1'b0}}, w_abs_a};
            r_mplier <= w_abs_b;
            r_neg    <= bus.in_signed &
                        (bus.in_a[W-1] ^ bus.in_b[W-1]);
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= BUSY;
          end
        end
        BUSY: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= w_mplier_nxt;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_prod  <= w_prod;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_prod  = r_prod;
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at W=8.
// Vector table plus backpressure and mid-operation reset sequences.
module tb_seq_multiplier;
  localparam int W = 8;

`ifdef SEQ_MULTIPLIER_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk;
  logic reset;

  seq_multiplier_if #(.W(W)) bus ();

  seq_multiplier #(.W(W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[15];
  int   n_cmp;
  int   n_bad;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [7:0] b, input logic s);
    logic [7:0] m;
    int l;
    m = (s && b[7]) ? -b : b;
    l = 1;
    for (int i = 0; i < 8; i++) if (m[i]) l = i + 1;
    return EARLY ? l : 8;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one operation and waits for DONE; leaves DONE unacknowledged.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b,
                          input logic s, output int lat);
    int guard;
    guard = 0;
    lat = -1;
    while (bus.in_ready !== 1'b1 && guard < 40) begin
      tick();
      guard++;
    end
    if (guard >= 40) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_signed = s;
    tick();
    bus.in_valid = 1'b0;
    bus.in_a     = 8'h5A;
    bus.in_b     = 8'hA5;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic ack();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  int lat;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    vecs[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    vecs[1]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
    vecs[2]  = '{8'h80, 8'h7F, 1'b1, 16'hC080};
    vecs[3]  = '{8'hFF, 8'h02, 1'b1, 16'hFFFE};
    vecs[4]  = '{8'hFF, 8'h02, 1'b0, 16'h01FE};
    vecs[5]  = '{8'h00, 8'hFF, 1'b1, 16'h0000};
    vecs[6]  = '{8'hFF, 8'h00, 1'b1, 16'h0000};
    vecs[7]  = '{8'h05, 8'h00, 1'b0, 16'h0000};
    vecs[8]  = '{8'h01, 8'h01, 1'b0, 16'h0001};
    vecs[9]  = '{8'h03, 8'h80, 1'b0, 16'h0180};
    vecs[10] = '{8'h03, 8'hFB, 1'b1, 16'hFFF1};
    vecs[11] = '{8'hFB, 8'hFB, 1'b1, 16'h0019};
    vecs[12] = '{8'h12, 8'h34, 1'b0, 16'h03A8};
    vecs[13] = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
    vecs[14] = '{8'h07, 8'h03, 1'b0, 16'h0015};

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_signed = 1'b0;
    bus.out_ready = 1'b0;
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_prod", 32'(bus.out_prod), 0);

    // out_ready outside DONE must not disturb anything
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("idle_out_ready", 32'(bus.in_ready), 1);

    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].s, lat);
      chk($sformatf("prod[%0d]", i), 32'(bus.out_prod), 32'(vecs[i].p));
      chk($sformatf("lat[%0d]", i), lat, exp_lat(vecs[i].b, vecs[i].s));
      ack();
      chk($sformatf("idle[%0d]", i), 32'(bus.in_ready), 1);
    end

    // Backpressure: DONE holds, in_valid pulses ignored
    start_op(8'h12, 8'h34, 1'b0, lat);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid  = k[0];
      bus.in_a      = 8'hFF;
      bus.in_b      = 8'hFF;
      bus.in_signed = 1'b1;
      tick();
      chk("bp_prod", 32'(bus.out_prod), 32'h03A8);
      chk("bp_in_ready", 32'(bus.in_ready), 0);
      chk("bp_out_valid", 32'(bus.out_valid), 1);
    end
    bus.in_valid = 1'b0;
    ack();
    chk("bp_idle", 32'(bus.in_ready), 1);
    chk("bp_valid_low", 32'(bus.out_valid), 0);
    tick();
    chk("bp_no_spurious", 32'(bus.in_ready), 1);

    // Reset on the 3rd BUSY cycle
    bus.in_valid  = 1'b1;
    bus.in_a      = 8'h55;
    bus.in_b      = 8'hFF;
    bus.in_signed = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_out_prod", 32'(bus.out_prod), 0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 1);
    start_op(8'h03, 8'hFB, 1'b1, lat);
    chk("post_rst_prod", 32'(bus.out_prod), 32'hFFF1);
    chk("post_rst_lat", lat, exp_lat(8'hFB, 1'b1));
    ack();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Iterative shift-add multiplier that replaces the fixed 8-bit combinational signed and unsigned multipliers with one parametrised unit. Each operation selects signed (two's-complement) or unsigned mode. A valid/ready handshake sits on both the operand side and the product side. It trades area for latency, retiring one multiplier bit per cycle, and is intended for datapaths where a full-width array multiplier is too large.

## Interface
- `W`, 8: operand width in bits; `W >= 2`. The product is `2*W` bits.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  operands and mode are presented.
- `in_ready`  out  1  unit can accept operands.
- `in_a`  in  W  multiplicand.
- `in_b`  in  W  multiplier.
- `in_signed`  in  1  1 = both operands two's-complement; 0 = both unsigned.
- `out_valid`  out  1  product is available.
- `out_ready`  in  1  consumer accepts the product.
- `out_prod`  out  2*W  product, which is exact and never overflows.

## Operation
- States: IDLE, BUSY, DONE.
  - IDLE -> BUSY on `in_valid & in_ready`.
  - BUSY -> DONE when the step counter reaches W. With early exit compiled in, BUSY also ends when the remaining multiplier bits are zero.
  - DONE -> IDLE on `out_ready`.
- `in_ready` = (state == IDLE). `out_valid` = (state == DONE). Both are registered-state decodes, with no combinational path from inputs.
- Operand capture happens at the accept edge:
  - In signed mode, store |a| and |b| as W-bit unsigned values. |-2^(W-1)| = 2^(W-1) fits.
  - Store the result sign as a[W-1] ^ b[W-1].
  - In unsigned mode, store the operands as-is with result sign 0.
- Each BUSY cycle:
  - If multiplier LSB = 1, add the multiplicand (zero-extended to 2W) into the accumulator.
  - Shift the multiplicand left by 1 and the multiplier right by 1.
  - Increment the step counter.
- On the BUSY -> DONE edge, `out_prod` gets the accumulator, two's-complement negated if the result sign = 1.
- `out_prod` holds stable throughout DONE, regardless of the inputs.
- Inputs are ignored outside IDLE. `in_a`, `in_b` and `in_signed` are sampled only at the accept edge.
- A zero operand in signed mode gives +0, never a negative-zero artefact.
- Reset (`reset` = 0 at an edge), including mid-operation:
  - State -> IDLE; the operation in progress is abandoned with no output.
  - `out_valid` = 0, `out_prod` = 0, accumulator and counter = 0.
  - `in_ready` = 1 from the first edge after `reset` returns high.

## Timing
- Latency: `out_valid` rises exactly W rising edges after the accept edge when the macro is off.
- Throughput with `out_ready` held high: one product every W+2 cycles (accept, W BUSY, DONE handshake). No overlap: the next accept occurs in IDLE, one cycle after the DONE handshake.
- Backpressure: DONE persists indefinitely while `out_ready` = 0.
- `out_ready` asserted in a non-DONE state has no effect.

## Configuration
- Macro: `SEQ_MULTIPLIER_EARLY_EXIT_EN`.
- Defined:
  - BUSY ends after the step in which the shifted multiplier register becomes zero, with a minimum of 1 BUSY cycle.
  - Latency = max(1, position of the highest set bit of |b| + 1).
  - Examples: b=0 -> 1, b=1 -> 1, b=3 -> 2, b=0x80 -> 8.
- Undefined: fixed latency of W cycles for every operand, and the zero-detect logic is absent.

## Structure
- Package `seq_multiplier_pkg` holds:
  - the `seq_mul_state_t` enum (IDLE, BUSY, DONE);
  - the localparam function computing counter width, `$clog2(W+1)`.
- Sub-module `cond_negate`, parametrised in width, performs out = neg ? -in : in. It is instantiated for |a|, |b| and the final sign fix.

## Test plan
- Unsigned, W=8, a=0xFF, b=0xFF -> `out_prod` = 0xFE01. `out_valid` is high exactly 8 edges after accept (macro off).
- Signed, a=0x80, b=0x80 -> 0x4000. Signed, a=0x80, b=0x7F -> 0xC080.
- Same operands, different mode: a=0xFF, b=0x02 -> signed gives 0xFFFE, unsigned gives 0x01FE.
- Backpressure:
  - Hold `out_ready` = 0 for 5 cycles in DONE, then pulse it for 1 cycle.
  - `out_prod` stays stable and `in_ready` stays 0 throughout the hold.
  - `in_valid` pulses during DONE are ignored.
  - State returns to IDLE one edge after the `out_ready` pulse.
- Reset mid-operation: assert `reset` = 0 on the 3rd BUSY cycle.
  - `out_valid` = 0, `out_prod` = 0 and `in_ready` = 1 on the first edge after `reset` returns high.
  - The next operation, signed 3 × -5, returns 0xFFF1.
- Early exit (macro on): b=1 -> latency 1; b=0 -> latency 1 and product 0; b=0x80 unsigned -> latency 8. With the macro off, all three take latency 8.
